// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: sequencing controller for the PC register and the instruction bus.
//
// Runs one outstanding fetch at a time on an SRAM-like bus (req/addr_ok/data_ok).
// Fetched words go to IF/ID under a stall handshake. A one-entry skid buffer holds a
// word that returns while IF/ID is stalled. Redirects (exception over eret) flush the
// PC register and cause any fetch already issued to be discarded when it returns.
//
// Optional build macro: FETCH_ADEL_CHECK_EN. When it is defined, a misaligned PC is not
// fetched. Instead an address-error marker is delivered on if_adel, and the controller
// waits for a redirect.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pc                         current PC register output
//   exc_valid, exc_pc          exception redirect request and vector
//   eret_valid, epc            eret redirect request and return address
//   dec_stall                  IF/ID cannot accept a new instruction
//   pc_en, pc_flush, newpc     PC register controls (advance, redirect, target)
//   inst_req, inst_addr        bus request and address
//   inst_addr_ok, inst_data_ok bus address accepted and read data valid
//   inst_rdata                 bus read data
//   if_valid, if_inst, if_pc   instruction to IF/ID and its PC
//   if_adel                    (FETCH_ADEL_CHECK_EN only) address-error marker
module pc_fetch_ctrl #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  input  logic             dec_stall,
  output logic             pc_en,
  output logic             pc_flush,
  output logic [WIDTH-1:0] newpc,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output logic             if_valid,
`ifdef FETCH_ADEL_CHECK_EN
  output logic             if_adel,
`endif
  output logic [31:0]      if_inst,
  output logic [WIDTH-1:0] if_pc
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

  state_e           state;
  logic             discard;
  logic [WIDTH-1:0] addr_q;
  logic [31:0]      skid_inst;
  logic [WIDTH-1:0] skid_pc;
  logic             redir;
  logic             accept;
  logic             misaligned;

  // RESET_PC belongs to the PC register; nothing in this controller depends on it.
  logic [WIDTH-1:0] unused_reset_pc;
  assign unused_reset_pc = RESET_PC;

`ifdef FETCH_ADEL_CHECK_EN
  // Set once the address-error marker for the current PC has been handed to IF/ID.
  logic adel_done;
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign redir    = exc_valid | eret_valid;
  assign pc_flush = redir;
  assign newpc    = exc_valid ? exc_pc : (eret_valid ? epc : '0);
  assign accept   = !(if_valid && dec_stall);

  // IDLE presents the live PC; ADDR replays the captured copy until it is accepted.
  assign inst_req  = !rst && ((state == StIdle && !misaligned) || state == StAddr);
  assign inst_addr = (state == StIdle) ? pc : addr_q;

  // Advance the PC only when a fetched word actually moves into the output registers.
  assign pc_en = !rst && !redir && accept &&
                 ((state == StData && inst_data_ok && !discard) || state == StHold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      discard   <= 1'b0;
      addr_q    <= '0;
      skid_inst <= '0;
      skid_pc   <= '0;
      if_valid  <= 1'b0;
      if_inst   <= '0;
      if_pc     <= '0;
`ifdef FETCH_ADEL_CHECK_EN
      if_adel   <= 1'b0;
      adel_done <= 1'b0;
`endif
    end else begin
      // Consumed or flushed output drops unless a load below refills it.
      if (redir || !dec_stall) begin
        if_valid <= 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
        if_adel  <= 1'b0;
`endif
      end
`ifdef FETCH_ADEL_CHECK_EN
      if (redir) adel_done <= 1'b0;
`endif

      unique case (state)
        StIdle: begin
`ifdef FETCH_ADEL_CHECK_EN
          if (misaligned) begin
            if (!redir && !adel_done && accept) begin
              if_valid  <= 1'b1;
              if_inst   <= '0;
              if_pc     <= pc;
              if_adel   <= 1'b1;
              adel_done <= 1'b1;
            end
          end else
`endif
          begin
            addr_q <= pc;
            if (inst_addr_ok) begin
              state   <= StData;
              // Accepted in the same cycle as a redirect: the reply is already stale.
              discard <= redir;
            end else if (!redir) begin
              state <= StAddr;
            end
          end
        end

        StAddr: begin
          if (redir) discard <= 1'b1;
          if (inst_addr_ok) state <= StData;
        end

        StData: begin
          if (inst_data_ok) begin
            state <= StIdle;
            if (discard || redir) begin
              discard <= 1'b0;
            end else if (accept) begin
              if_valid <= 1'b1;
              if_inst  <= inst_rdata;
              if_pc    <= addr_q;
`ifdef FETCH_ADEL_CHECK_EN
              if_adel  <= 1'b0;
`endif
            end else begin
              skid_inst <= inst_rdata;
              skid_pc   <= addr_q;
              state     <= StHold;
            end
          end else if (redir) begin
            discard <= 1'b1;
          end
        end

        StHold: begin
          if (redir) begin
            skid_inst <= '0;
            skid_pc   <= '0;
            state     <= StIdle;
          end else if (accept) begin
            if_valid <= 1'b1;
            if_inst  <= skid_inst;
            if_pc    <= skid_pc;
`ifdef FETCH_ADEL_CHECK_EN
            if_adel  <= 1'b0;
`endif
            state    <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed sequences, a table of redirect vectors, and a
// randomized run checked against a transaction-level model of the fetch path.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] ResetPc = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        exc_valid, eret_valid, dec_stall;
  logic [31:0] exc_pc, epc;
  logic        pc_en, pc_flush;
  logic [31:0] newpc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;
`ifdef FETCH_ADEL_CHECK_EN
  logic        if_adel;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.WIDTH(32), .RESET_PC(ResetPc)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .eret_valid   (eret_valid),
    .epc          (epc),
    .dec_stall    (dec_stall),
    .pc_en        (pc_en),
    .pc_flush     (pc_flush),
    .newpc        (newpc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
`ifdef FETCH_ADEL_CHECK_EN
    .if_adel      (if_adel),
`endif
    .if_inst      (if_inst),
    .if_pc        (if_pc)
  );

  // The PC register the controller sequences.
  always @(posedge clk) begin
    if (rst)           pc <= ResetPc;
    else if (pc_flush) pc <= newpc;
    else if (pc_en)    pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    exc_valid = 0; eret_valid = 0; exc_pc = '0; epc = '0; dec_stall = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
  endtask

  typedef struct {
    logic        exc;
    logic        eret;
    logic [31:0] xpc;
    logic [31:0] rpc;
    logic        e_flush;
    logic [31:0] e_newpc;
  } redir_vec_t;

  redir_vec_t vecs[6];

  // Transaction-level model: a request waiting for acceptance, a fetch in flight
  // (with a stale flag), a skid queue of returned words, and the IF/ID output.
  bit          m_wait, m_infl, m_stale, m_ov;
  logic [31:0] m_addr, m_oi, m_op;
  logic [63:0] m_skid[$];
  bit          slave_pending;

  initial begin
    vecs[0] = '{0, 0, 32'h11111110, 32'h22222220, 0, 32'h0};
    vecs[1] = '{1, 0, 32'hbfc00380, 32'h80001000, 1, 32'hbfc00380};
    vecs[2] = '{0, 1, 32'hbfc00380, 32'h80001000, 1, 32'h80001000};
    vecs[3] = '{1, 1, 32'hbfc00380, 32'h80001000, 1, 32'hbfc00380};
    vecs[4] = '{1, 1, 32'h00000180, 32'h12345678, 1, 32'h00000180};
    vecs[5] = '{0, 0, 32'h0, 32'h0, 0, 32'h0};

    clear_in();
    rst = 1;
    tick();
    tick();
    chk("rst_req", inst_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_pc", if_pc, 0);

    // First fetch: addr_ok one cycle late, data two cycles after acceptance.
    rst = 0; #1;
    chk("f1_req_idle", inst_req, 1);
    chk("f1_addr_idle", inst_addr, ResetPc);
    tick();
    inst_addr_ok = 1; #1;
    chk("f1_req_addr", inst_req, 1);
    chk("f1_addr_addr", inst_addr, ResetPc);
    tick();
    inst_addr_ok = 0; #1;
    chk("f1_req_data", inst_req, 0);
    chk("f1_pc_en_wait", pc_en, 0);
    tick();
    inst_data_ok = 1; inst_rdata = 32'h24080001; #1;
    chk("f1_pc_en", pc_en, 1);
    tick();

    // Second fetch returns while IF/ID is stalled.
    inst_data_ok = 0; dec_stall = 1; inst_addr_ok = 1; #1;
    chk("f1_if_valid", if_valid, 1);
    chk("f1_if_inst", if_inst, 32'h24080001);
    chk("f1_if_pc", if_pc, ResetPc);
    chk("f1_pc_en_after", pc_en, 0);
    chk("f2_addr", inst_addr, 32'hbfc00004);
    tick();
    inst_addr_ok = 0; inst_data_ok = 1; inst_rdata = 32'h0; #1;
    chk("f2_stall_pc_en", pc_en, 0);
    tick();
    inst_data_ok = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hold_pc_en", pc_en, 0);
      chk("hold_req", inst_req, 0);
      chk("hold_if_inst", if_inst, 32'h24080001);
      tick();
    end
    dec_stall = 0; #1;
    chk("skid_pc_en", pc_en, 1);
    tick();
    inst_addr_ok = 1; #1;
    chk("skid_if_valid", if_valid, 1);
    chk("skid_if_inst", if_inst, 32'h0);
    chk("skid_if_pc", if_pc, 32'hbfc00004);
    chk("skid_pc_en_once", pc_en, 0);
    chk("f3_addr", inst_addr, 32'hbfc00008);
    tick();

    // Exception while in DATA: the reply must be dropped.
    inst_addr_ok = 0; exc_valid = 1; exc_pc = 32'hbfc00380; #1;
    chk("exc_flush", pc_flush, 1);
    chk("exc_newpc", newpc, 32'hbfc00380);
    chk("exc_pc_en", pc_en, 0);
    tick();
    exc_valid = 0; exc_pc = '0; #1;
    chk("exc_if_valid", if_valid, 0);
    chk("exc_req_data", inst_req, 0);
    tick();
    inst_data_ok = 1; inst_rdata = 32'hdeadbeef; #1;
    chk("stale_pc_en", pc_en, 0);
    tick();
    inst_data_ok = 0; #1;
    chk("stale_if_valid", if_valid, 0);
    chk("exc_req", inst_req, 1);
    chk("exc_req_addr", inst_addr, 32'hbfc00380);

    // Redirect arbitration table, applied in IDLE with addr_ok low.
    for (int i = 0; i < 6; i++) begin
      exc_valid = vecs[i].exc; eret_valid = vecs[i].eret;
      exc_pc = vecs[i].xpc; epc = vecs[i].rpc; #1;
      chk($sformatf("vec%0d_flush", i), pc_flush, vecs[i].e_flush);
      chk($sformatf("vec%0d_newpc", i), newpc, vecs[i].e_newpc);
      chk($sformatf("vec%0d_pc_en", i), pc_en, 0);
    end
    tick();

    // addr_ok withheld for four cycles.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wait_req", inst_req, 1);
      chk("wait_addr", inst_addr, 32'hbfc00380);
      tick();
    end
    inst_addr_ok = 1; #1;
    chk("wait_addr_acc", inst_addr, 32'hbfc00380);
    tick();

    // Reset in DATA, then a late data_ok.
    inst_addr_ok = 0; rst = 1;
    tick();
    rst = 0; inst_data_ok = 1; inst_rdata = 32'hcafef00d; #1;
    chk("late_if_valid", if_valid, 0);
    chk("late_if_pc", if_pc, 0);
    chk("late_if_inst", if_inst, 0);
    chk("late_pc_en", pc_en, 0);
    chk("late_addr", inst_addr, ResetPc);
    tick();
    inst_data_ok = 0; #1;
    chk("late_if_valid2", if_valid, 0);

`ifdef FETCH_ADEL_CHECK_EN
    exc_valid = 1; exc_pc = 32'hbfc00002;
    tick();
    exc_valid = 0; exc_pc = '0; #1;
    chk("adel_no_req", inst_req, 0);
    tick();
    chk("adel_if_valid", if_valid, 1);
    chk("adel_if_adel", if_adel, 1);
    chk("adel_if_inst", if_inst, 0);
    chk("adel_if_pc", if_pc, 32'hbfc00002);
    chk("adel_no_req2", inst_req, 0);
    tick();
    chk("adel_clear", if_adel, 0);
    chk("adel_wait", inst_req, 0);
    exc_valid = 1; exc_pc = ResetPc;
    tick();
    exc_valid = 0; exc_pc = '0;
`endif

    // Randomized run against the model.
    clear_in();
    rst = 1;
    tick();
    rst = 0;
    m_wait = 0; m_infl = 0; m_stale = 0; m_ov = 0;
    m_addr = '0; m_oi = '0; m_op = '0; m_skid.delete();
    slave_pending = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          redir, busy, acc, e_req, e_en, load;
      logic [31:0] e_addr, e_newpc, l_inst, l_pc;
      logic [63:0] item;
      exc_valid    = (($urandom % 16) == 0);
      eret_valid   = (($urandom % 16) == 0);
      exc_pc       = $urandom & 32'hffff_fffc;
      epc          = $urandom & 32'hffff_fffc;
      dec_stall    = (($urandom % 3) == 0);
      inst_addr_ok = $urandom % 2;
      inst_data_ok = slave_pending && (($urandom % 2) == 0);
      inst_rdata   = $urandom;
      #1;
      redir   = exc_valid || eret_valid;
      busy    = m_wait || m_infl || (m_skid.size() != 0);
      e_req   = m_wait || !busy;
      e_addr  = m_wait ? m_addr : pc;
      acc     = !(m_ov && dec_stall);
      e_en    = !redir && acc &&
                ((m_skid.size() != 0) || (m_infl && inst_data_ok && !m_stale));
      e_newpc = exc_valid ? exc_pc : (eret_valid ? epc : 32'h0);
      chk("rnd_req", inst_req, e_req);
      if (e_req) chk("rnd_addr", inst_addr, e_addr);
      chk("rnd_pc_en", pc_en, e_en);
      chk("rnd_flush", pc_flush, redir);
      chk("rnd_newpc", newpc, e_newpc);
      chk("rnd_if_valid", if_valid, m_ov);
      if (m_ov) begin
        chk("rnd_if_inst", if_inst, m_oi);
        chk("rnd_if_pc", if_pc, m_op);
      end

      load = 0; l_inst = '0; l_pc = '0;
      if (m_skid.size() != 0) begin
        if (redir) m_skid.delete();
        else if (acc) begin
          item = m_skid.pop_front();
          load = 1; l_inst = item[63:32]; l_pc = item[31:0];
        end
      end else if (m_infl) begin
        if (inst_data_ok) begin
          m_infl = 0;
          if (!m_stale && !redir) begin
            if (acc) begin load = 1; l_inst = inst_rdata; l_pc = m_addr; end
            else m_skid.push_back({inst_rdata, m_addr});
          end
          m_stale = 0;
        end else if (redir) m_stale = 1;
      end else if (m_wait) begin
        if (redir) m_stale = 1;
        if (inst_addr_ok) begin m_wait = 0; m_infl = 1; end
      end else begin
        if (inst_addr_ok) begin m_infl = 1; m_addr = pc; m_stale = redir; end
        else if (!redir) begin m_wait = 1; m_addr = pc; end
      end
      if (redir) m_ov = 0;
      else if (load) begin m_ov = 1; m_oi = l_inst; m_op = l_pc; end
      else if (!dec_stall) m_ov = 0;

      if (inst_data_ok) slave_pending = 0;
      if (inst_req && inst_addr_ok) slave_pending = 1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
